// File: rtl/pio_fifo.sv
// pio_fifo: host-side TX/RX FIFO pair for one PIO state machine.
// Both FIFOs share one array of 2*DEPTH words. With no join, TX owns the
// lower half and RX owns the upper half. A join mode gives the whole array
// to one direction, and the other direction gets zero capacity.
// The levels are the only source of full/empty. Capacities come from the
// registered mode. During the flush cycle that follows a mode change, the
// old geometry stays in force and all strobes are ignored.
module pio_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               join_tx,
   input  logic                               join_rx,
   input  logic                               tx_wr,
   input  logic [WIDTH-1:0]                   tx_wdata,
   input  logic                               rx_rd,
   output logic [WIDTH-1:0]                   rx_rdata,
   input  logic                               pull,
   output logic [WIDTH-1:0]                   pull_data,
   output logic                               pull_stall,
   input  logic                               push,
   input  logic [WIDTH-1:0]                   push_data,
   output logic                               push_stall,
   output logic                               tx_full,
   output logic                               tx_empty,
   output logic                               rx_full,
   output logic                               rx_empty,
   output logic [$clog2(2*DEPTH):0]           tx_level,
   output logic [$clog2(2*DEPTH):0]           rx_level,
   output logic [3:0]                         flags,
   input  logic [3:0]                         flag_clr
);

   localparam int PW = $clog2(2*DEPTH);
   localparam int LW = PW + 1;

   typedef enum logic [1:0] {
      MODE_SPLIT = 2'd0,
      MODE_JTX   = 2'd1,
      MODE_JRX   = 2'd2
   } mode_t;

   mode_t            mode_s, mode_q, mode_d;
   logic             flush_s;
   logic [LW-1:0]    tx_cap_s, rx_cap_s;
   logic [PW-1:0]    rx_base_s;

   logic [WIDTH-1:0] mem_q [2*DEPTH];
   logic [WIDTH-1:0] mem_d [2*DEPTH];

   logic [PW-1:0]    tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
   logic [PW-1:0]    rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
   logic [LW-1:0]    tx_level_q, tx_level_d, rx_level_q, rx_level_d;
   logic [3:0]       flags_q, flags_d, flag_set_s;

   logic             tx_pop_s, tx_acc_s, rx_pop_s, rx_acc_s;
   logic [PW-1:0]    rx_waddr_s, rx_raddr_s;

   // Pointer advance with wrap to 0 past cap-1.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p,
                                             input logic [LW-1:0] cap);
      if ({1'b0, p} == (cap - LW'(1))) begin
         ptr_inc = '0;
      end else begin
         ptr_inc = p + PW'(1);
      end
   endfunction

   // Resolve the effective mode from the join inputs; join_tx has priority.
   always_comb begin
      mode_s = MODE_SPLIT;
      if (join_tx) begin
         mode_s = MODE_JTX;
      end else if (join_rx) begin
         mode_s = MODE_JRX;
      end else begin
         mode_s = MODE_SPLIT;
      end
   end

   // Derive the capacities and the RX window base from the registered mode.
   always_comb begin
      case (mode_q)
         MODE_JTX: begin
            tx_cap_s  = LW'(2*DEPTH);
            rx_cap_s  = '0;
            rx_base_s = '0;
         end
         MODE_JRX: begin
            tx_cap_s  = '0;
            rx_cap_s  = LW'(2*DEPTH);
            rx_base_s = '0;
         end
         default: begin
            tx_cap_s  = LW'(DEPTH);
            rx_cap_s  = LW'(DEPTH);
            rx_base_s = PW'(DEPTH);
         end
      endcase
   end

   assign flush_s    = (mode_s != mode_q);
   assign tx_full    = (tx_level_q == tx_cap_s);
   assign tx_empty   = (tx_level_q == '0);
   assign rx_full    = (rx_level_q == rx_cap_s);
   assign rx_empty   = (rx_level_q == '0);
   assign tx_level   = tx_level_q;
   assign rx_level   = rx_level_q;
   assign flags      = flags_q;
   assign rx_waddr_s = rx_base_s + rx_wptr_q;
   assign rx_raddr_s = rx_base_s + rx_rptr_q;

   // A write into a full FIFO is accepted when a real pop happens in the same cycle.
   assign tx_pop_s   = pull & ~tx_empty & ~flush_s;
   assign tx_acc_s   = tx_wr & ~flush_s & (~tx_full | tx_pop_s);
   assign rx_pop_s   = rx_rd & ~rx_empty & ~flush_s;
   assign rx_acc_s   = push & ~flush_s & (~rx_full | rx_pop_s);

   // The stall outputs depend only on the strobes and the current levels, so the machine sees them at once.
   assign pull_stall = pull & tx_empty;
   assign push_stall = push & rx_full & ~(rx_rd & ~rx_empty);

   // Each FIFO head falls through to its output and reads as 0 when that FIFO is empty.
   assign pull_data  = tx_empty ? '0 : mem_q[tx_rptr_q];
   assign rx_rdata   = rx_empty ? '0 : mem_q[rx_raddr_s];

   // Compute the next pointers, levels, mode and sticky flags.
   always_comb begin
      mode_d     = mode_s;
      tx_wptr_d  = tx_wptr_q;
      tx_rptr_d  = tx_rptr_q;
      rx_wptr_d  = rx_wptr_q;
      rx_rptr_d  = rx_rptr_q;
      tx_level_d = tx_level_q;
      rx_level_d = rx_level_q;
      flag_set_s = 4'b0000;
      if (flush_s) begin
         tx_wptr_d  = '0;
         tx_rptr_d  = '0;
         rx_wptr_d  = '0;
         rx_rptr_d  = '0;
         tx_level_d = '0;
         rx_level_d = '0;
      end else begin
         flag_set_s[0] = push & ~rx_acc_s;
         flag_set_s[1] = tx_wr & ~tx_acc_s;
         flag_set_s[2] = rx_rd & rx_empty;
         flag_set_s[3] = pull & tx_empty;
         if (tx_acc_s) begin
            tx_wptr_d = ptr_inc(tx_wptr_q, tx_cap_s);
         end else begin
            tx_wptr_d = tx_wptr_q;
         end
         if (tx_pop_s) begin
            tx_rptr_d = ptr_inc(tx_rptr_q, tx_cap_s);
         end else begin
            tx_rptr_d = tx_rptr_q;
         end
         if (rx_acc_s) begin
            rx_wptr_d = ptr_inc(rx_wptr_q, rx_cap_s);
         end else begin
            rx_wptr_d = rx_wptr_q;
         end
         if (rx_pop_s) begin
            rx_rptr_d = ptr_inc(rx_rptr_q, rx_cap_s);
         end else begin
            rx_rptr_d = rx_rptr_q;
         end
         case ({tx_acc_s, tx_pop_s})
            2'b10:   tx_level_d = tx_level_q + LW'(1);
            2'b01:   tx_level_d = tx_level_q - LW'(1);
            default: tx_level_d = tx_level_q;
         endcase
         case ({rx_acc_s, rx_pop_s})
            2'b10:   rx_level_d = rx_level_q + LW'(1);
            2'b01:   rx_level_d = rx_level_q - LW'(1);
            default: rx_level_d = rx_level_q;
         endcase
      end
      // A flag set wins over a clear in the same cycle. A flush leaves the flags alone.
      flags_d = (flags_q & ~flag_clr) | flag_set_s;
   end

   // Compute the next storage contents from the two write ports, which never hit the same word.
   always_comb begin
      mem_d = mem_q;
      if (tx_acc_s) begin
         mem_d[tx_wptr_q] = tx_wdata;
      end else begin
         mem_d = mem_d;
      end
      if (rx_acc_s) begin
         mem_d[rx_waddr_s] = push_data;
      end else begin
         mem_d = mem_d;
      end
   end

   // Register the control state; reset returns to the unjoined mode with both FIFOs empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q     <= MODE_SPLIT;
         tx_wptr_q  <= '0;
         tx_rptr_q  <= '0;
         rx_wptr_q  <= '0;
         rx_rptr_q  <= '0;
         tx_level_q <= '0;
         rx_level_q <= '0;
         flags_q    <= 4'b0000;
      end else begin
         mode_q     <= mode_d;
         tx_wptr_q  <= tx_wptr_d;
         tx_rptr_q  <= tx_rptr_d;
         rx_wptr_q  <= rx_wptr_d;
         rx_rptr_q  <= rx_rptr_d;
         tx_level_q <= tx_level_d;
         rx_level_q <= rx_level_d;
         flags_q    <= flags_d;
      end
   end

   // Register the storage array; a stale word is never visible because the outputs are gated by empty.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_pio_fifo.sv
// Self-checking bench for pio_fifo. A queue-based model predicts every
// output on every cycle. Directed literal checks pin the model, and a long
// randomized run follows.
module tb_pio_fifo;
   localparam int D  = 4;
   localparam int W  = 32;
   localparam int LW = $clog2(2*D) + 1;

   logic          clk = 1'b0;
   logic          reset, join_tx, join_rx, tx_wr, rx_rd, pull, push, push_stall, pull_stall;
   logic [W-1:0]  tx_wdata, push_data, rx_rdata, pull_data;
   logic          tx_full, tx_empty, rx_full, rx_empty;
   logic [LW-1:0] tx_level, rx_level;
   logic [3:0]    flags, flag_clr;

   int checks = 0;
   int errors = 0;

   logic [31:0] txq[$];
   logic [31:0] rxq[$];
   int          m_mode;
   logic [3:0]  m_flags;

   always #5 clk = ~clk;

   pio_fifo #(.DEPTH(D), .WIDTH(W)) dut (
      .clk(clk), .reset(reset), .join_tx(join_tx), .join_rx(join_rx),
      .tx_wr(tx_wr), .tx_wdata(tx_wdata), .rx_rd(rx_rd), .rx_rdata(rx_rdata),
      .pull(pull), .pull_data(pull_data), .pull_stall(pull_stall),
      .push(push), .push_data(push_data), .push_stall(push_stall),
      .tx_full(tx_full), .tx_empty(tx_empty), .rx_full(rx_full), .rx_empty(rx_empty),
      .tx_level(tx_level), .rx_level(rx_level), .flags(flags), .flag_clr(flag_clr)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int tcap();
      return (m_mode == 1) ? 2*D : (m_mode == 2) ? 0 : D;
   endfunction
   function automatic int rcap();
      return (m_mode == 2) ? 2*D : (m_mode == 1) ? 0 : D;
   endfunction

   // Compare every DUT output against the model's view of the current cycle.
   task automatic compare_all();
      int  ts, rs;
      logic te, re, rf;
      ts = txq.size();
      rs = rxq.size();
      te = (ts == 0);
      re = (rs == 0);
      rf = (rs == rcap());
      chk("tx_level", 32'(tx_level), 32'(ts));
      chk("rx_level", 32'(rx_level), 32'(rs));
      chk("tx_full", 32'(tx_full), 32'(ts == tcap()));
      chk("tx_empty", 32'(tx_empty), 32'(te));
      chk("rx_full", 32'(rx_full), 32'(rf));
      chk("rx_empty", 32'(rx_empty), 32'(re));
      chk("pull_data", pull_data, te ? 32'h0 : txq[0]);
      chk("rx_rdata", rx_rdata, re ? 32'h0 : rxq[0]);
      chk("pull_stall", 32'(pull_stall), 32'(pull & te));
      chk("push_stall", 32'(push_stall), 32'(push & rf & ~(rx_rd & ~re)));
      chk("flags", 32'(flags), 32'(m_flags));
   endtask

   // Advance the model across one clock edge using the inputs currently driven.
   task automatic model_edge();
      int  nm, ts, rs;
      logic tpop, tacc, rpop, racc;
      logic [3:0] set;
      if (reset) begin
         txq.delete();
         rxq.delete();
         m_flags = 4'b0000;
         m_mode  = 0;
      end else begin
         nm  = join_tx ? 1 : (join_rx ? 2 : 0);
         set = 4'b0000;
         if (nm != m_mode) begin
            txq.delete();
            rxq.delete();
            m_mode = nm;
         end else begin
            ts   = txq.size();
            rs   = rxq.size();
            tpop = pull && (ts > 0);
            tacc = tx_wr && ((ts < tcap()) || tpop);
            rpop = rx_rd && (rs > 0);
            racc = push && ((rs < rcap()) || rpop);
            set[0] = push & ~racc;
            set[1] = tx_wr & ~tacc;
            set[2] = rx_rd & (rs == 0);
            set[3] = pull & (ts == 0);
            if (tpop) void'(txq.pop_front());
            if (tacc) txq.push_back(tx_wdata);
            if (rpop) void'(rxq.pop_front());
            if (racc) rxq.push_back(push_data);
         end
         m_flags = (m_flags & ~flag_clr) | set;
      end
   endtask

   // One cycle: sample away from the edge, compare, then advance across the edge.
   task automatic step();
      #1;
      compare_all();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle();
      reset = 1'b0; tx_wr = 1'b0; rx_rd = 1'b0; pull = 1'b0; push = 1'b0;
      flag_clr = 4'b0000;
   endtask

   task automatic tx_write(input logic [31:0] d);
      tx_wr = 1'b1; tx_wdata = d; step(); tx_wr = 1'b0;
   endtask

   task automatic do_push(input logic [31:0] d);
      push = 1'b1; push_data = d; step(); push = 1'b0;
   endtask

   task automatic do_pull();
      pull = 1'b1; step(); pull = 1'b0;
   endtask

   task automatic do_rd();
      rx_rd = 1'b1; step(); rx_rd = 1'b0;
   endtask

   initial begin
      m_mode = 0; m_flags = 4'b0000;
      join_tx = 1'b0; join_rx = 1'b0; tx_wdata = '0; push_data = '0;
      idle();
      reset = 1'b1;
      @(negedge clk);
      step();
      step();
      reset = 1'b0;
      chk("rst_tx_empty", 32'(tx_empty), 32'd1);
      chk("rst_rx_empty", 32'(rx_empty), 32'd1);
      chk("rst_tx_full", 32'(tx_full), 32'd0);
      chk("rst_flags", 32'(flags), 32'd0);
      chk("rst_pull_data", pull_data, 32'd0);

      // Fill and drain in order, with an overflow on the fifth write.
      for (int i = 0; i < 5; i++) tx_write(32'hA0 + 32'(i));
      step();
      chk("fill_full", 32'(tx_full), 32'd1);
      chk("fill_over", 32'(flags[1]), 32'd1);
      chk("fill_level", 32'(tx_level), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk("drain_head", pull_data, 32'hA0 + 32'(i));
         do_pull();
      end
      chk("drain_empty", 32'(tx_empty), 32'd1);

      // A pull on an empty FIFO stalls and sets the flag; a same-cycle set beats a clear.
      flag_clr = 4'b1111; step(); flag_clr = 4'b0000;
      pull = 1'b1; #1;
      chk("pe_stall", 32'(pull_stall), 32'd1);
      step(); pull = 1'b0;
      chk("pe_flag", 32'(flags[3]), 32'd1);
      chk("pe_level", 32'(tx_level), 32'd0);
      flag_clr = 4'b1000; step(); flag_clr = 4'b0000;
      chk("pe_clr", 32'(flags[3]), 32'd0);
      pull = 1'b1; flag_clr = 4'b1000; step(); idle();
      chk("pe_setwins", 32'(flags[3]), 32'd1);
      flag_clr = 4'b1111; step(); idle();

      // A write plus a pop on a full FIFO: the level holds and the new word ends up last.
      for (int i = 0; i < 4; i++) tx_write(32'hB0 + 32'(i));
      tx_wr = 1'b1; tx_wdata = 32'h55; pull = 1'b1; step(); idle();
      chk("sf_level", 32'(tx_level), 32'd4);
      chk("sf_noover", 32'(flags[1]), 32'd0);
      chk("sf_head", pull_data, 32'hB1);
      for (int i = 0; i < 4; i++) do_pull();
      // A write plus a pull on an empty FIFO: the write is taken and the pull stalls.
      tx_wr = 1'b1; tx_wdata = 32'h66; pull = 1'b1; #1;
      chk("se_stall", 32'(pull_stall), 32'd1);
      step(); idle();
      chk("se_level", 32'(tx_level), 32'd1);
      chk("se_head", pull_data, 32'h66);
      do_pull();
      flag_clr = 4'b1111; step(); idle();

      // RX path: fill the FIFO, overflow it, drain it, then underflow it.
      for (int i = 0; i < 4; i++) do_push(32'h11 * 32'(i + 1));
      push = 1'b1; push_data = 32'h55; #1;
      chk("rx_pstall", 32'(push_stall), 32'd1);
      step(); push = 1'b0;
      chk("rx_flag0", 32'(flags[0]), 32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("rx_head", rx_rdata, 32'h11 * 32'(i + 1));
         do_rd();
      end
      rx_rd = 1'b1; #1;
      chk("rx_under_data", rx_rdata, 32'd0);
      step(); rx_rd = 1'b0;
      chk("rx_flag2", 32'(flags[2]), 32'd1);
      flag_clr = 4'b1111; step(); idle();

      // Join TX: both FIFOs flush, TX then holds 8 words with wrap, and RX is disabled.
      tx_write(32'h1); tx_write(32'h2);
      join_tx = 1'b1; step();
      step();
      chk("jt_flushed", 32'(tx_level), 32'd0);
      for (int i = 0; i < 8; i++) tx_write(32'hC0 + 32'(i));
      chk("jt_full8", 32'(tx_level), 32'd8);
      chk("jt_rxfull", 32'(rx_full), 32'd1);
      chk("jt_rxempty", 32'(rx_empty), 32'd1);
      push = 1'b1; push_data = 32'h9; #1;
      chk("jt_pstall", 32'(push_stall), 32'd1);
      step(); push = 1'b0;
      do_pull(); do_pull();
      tx_write(32'hC8); tx_write(32'hC9);
      for (int i = 0; i < 8; i++) begin
         chk("jt_order", pull_data, 32'hC2 + 32'(i));
         do_pull();
      end
      join_tx = 1'b0; step(); step();
      flag_clr = 4'b1111; step(); idle();

      // Reset in the middle of operation discards the contents and clears the flags.
      do_rd();
      for (int i = 0; i < 5; i++) tx_write(32'hD0 + 32'(i));
      do_pull();
      do_push(32'hE0); do_push(32'hE1);
      chk("mr_pre_flags", 32'(flags), 32'b0110);
      chk("mr_pre_lvl", 32'(tx_level), 32'd3);
      reset = 1'b1; step(); reset = 1'b0;
      chk("mr_txlvl", 32'(tx_level), 32'd0);
      chk("mr_rxlvl", 32'(rx_level), 32'd0);
      chk("mr_flags", 32'(flags), 32'd0);
      chk("mr_pdata", pull_data, 32'd0);
      chk("mr_rdata", rx_rdata, 32'd0);

      // Randomized traffic against the model, with occasional mode changes and resets.
      for (int c = 0; c < 4000; c++) begin
         tx_wr    = ($urandom_range(0, 1) == 1);
         pull     = ($urandom_range(0, 2) == 0);
         push     = ($urandom_range(0, 1) == 1);
         rx_rd    = ($urandom_range(0, 2) == 0);
         tx_wdata = $urandom;
         push_data = $urandom;
         flag_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
         reset    = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 99) == 0) begin
            join_tx = 1'($urandom);
            join_rx = 1'($urandom);
         end
         step();
      end
      idle();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
